iso14443a_mode_sequencer: RTL and testbench
===========================================

# iso14443a_mode_sequencer

Sequences the `mod_type` control of the ISO14443-A high-frequency front end (`hi_iso14443a`) between listen, modulate and sniff modes. A transmit request is turned into a guarded window of exactly N SSP frames of modulation, with status reported on completion. The block sits between the configuration/command path from the ARM and the `hi_iso14443a` datapath. It runs in the `ck_1356meg` domain, the same domain that generates `ssp_frame`.

## Interface
- `GUARD_CYCLES`, default 16: listen-mode cycles inserted before and after the modulation window; legal range 1..255.
- `FRAME_TIMEOUT`, default 1024: maximum cycles between `ssp_frame` rising edges in MOD before abandoning; legal range 2..65535.

- `ck_1356meg`  in  1  13.56 MHz clock, all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `role`  in  1  0 = tag simulation, 1 = reader.
- `sniff`  in  1  1 = request SNIFFER mode while idle.
- `ssp_frame`  in  1  frame strobe from the datapath, synchronous to `ck_1356meg`.
- `tx_req`  in  1  single-cycle transmit request; only accepted in IDLE.
- `tx_frames`  in  8  number of frames to modulate; sampled with `tx_req`.
- `abort`  in  1  level; ends an active transmit early.
- `mod_type`  out  3  registered mode code to the datapath.
- `tx_busy`  out  1  high from the cycle after acceptance until `tx_done`.
- `tx_done`  out  1  one-cycle completion pulse.
- `tx_status`  out  2  valid with `tx_done`, held until the next acceptance: 00 ok, 01 aborted, 10 timeout, 11 rejected.

## Operation
- Mode codes:
  - SNIFFER 000
  - TAGSIM_LISTEN 001
  - TAGSIM_MOD 010
  - READER_LISTEN 011
  - READER_MOD 100
  - 101..111 are never driven.
- Listen code = role ? 011 : 001. Modulate code = role ? 100 : 010. The role used during a transmit is latched at acceptance.
- States: IDLE, GUARD_IN, MOD, GUARD_OUT, DONE.
- IDLE
  - `mod_type` = sniff ? 000 : listen(role), re-evaluated every cycle.
  - `tx_req` with sniff=0 and `tx_frames`≠0 is accepted: go to GUARD_IN, load the guard counter, latch role and frames.
  - `tx_req` with sniff=1 or `tx_frames`=0 is rejected: go to DONE with status 11. The block never enters MOD, and `tx_busy` stays 0.
- GUARD_IN
  - `mod_type` = latched listen code.
  - Lasts exactly `GUARD_CYCLES` cycles, then go to MOD.
- MOD
  - `mod_type` = latched modulate code.
  - Frame counter decrements on each `ssp_frame` rising edge, detected against a registered copy of `ssp_frame`. The registered copy is cleared on entry to MOD, so a frame already high at entry counts as an edge.
  - Counter reaching 0: go to GUARD_OUT, status ok.
- GUARD_OUT
  - `mod_type` = latched listen code.
  - Lasts `GUARD_CYCLES` cycles, then go to DONE.
- DONE
  - `tx_done`=1 for one cycle; `tx_busy` drops in the same cycle.
  - Next state IDLE.
- Abort
  - `abort` in GUARD_IN or MOD: go directly to GUARD_OUT with status 01.
  - `abort` in GUARD_OUT is ignored (status unchanged).
  - `abort` in IDLE, or in DONE after a rejected request, has no effect.
- Simultaneous events
  - abort and the final frame edge in the same cycle: abort wins, status 01.
  - timeout and abort in the same cycle: abort wins.
  - `tx_req` outside IDLE is dropped silently.
- `sniff` and `role` changes during a transmit do not affect it.

## Timing
- Reset values:
  - `mod_type`=001
  - `tx_busy`=0
  - `tx_done`=0
  - `tx_status`=00
  - state IDLE, all counters 0.
- Reset mid-transmit returns all outputs to the reset values on assertion. No `tx_done` pulse is produced.
- Accepted request at cycle T:
  - `tx_busy`=1 and GUARD_IN from T+1.
  - `mod_type`=MOD from T+1+`GUARD_CYCLES`.
- Last frame edge seen at cycle F: `mod_type` = listen from F+1.
- `tx_done` and `tx_status` appear at F+1+`GUARD_CYCLES`.
- Rejected request at T: `tx_done` at T+1, `tx_status`=11.
- `tx_frames`=255 is legal; the 8-bit counter never wraps.
- The IDLE `mod_type` follows `sniff`/`role` with one cycle of latency.

## Configuration
- `MODSEQ_TIMEOUT_EN`, when defined:
  - A 16-bit watchdog resets on MOD entry and on every `ssp_frame` rising edge.
  - Reaching `FRAME_TIMEOUT` goes to GUARD_OUT with status 10.
- When undefined:
  - No watchdog logic; MOD ends only on frame count or abort.
  - Status 10 is never produced.

## Test plan
- Reset then idle, role=0, sniff=0 → `mod_type`=001. Set sniff=1 → 000 one cycle later. Set role=1, sniff=0 → 011.
- role=0, `tx_req` with `tx_frames`=3, `ssp_frame` pulsing every 32 cycles, `GUARD_CYCLES`=16:
  - 010 appears 17 cycles after the request.
  - Exactly 3 rising edges of `ssp_frame` occur in MOD.
  - Then 16 cycles of 001, then `tx_done` with `tx_status`=00.
- `tx_req` with `tx_frames`=0, and separately with sniff=1 → `tx_done` one cycle later, `tx_status`=11, `mod_type` never 010/100.
- role=1, 5 frames requested, `abort` after the 2nd edge → `mod_type` 100 then 011, `tx_status`=01. `abort` coincident with the final edge → still 01.
- `MODSEQ_TIMEOUT_EN` defined, `FRAME_TIMEOUT`=64, `ssp_frame` held low in MOD → return to listen 64 cycles after MOD entry, `tx_status`=10.
- `reset` asserted during MOD → `mod_type`=001, `tx_busy`=0 immediately, no `tx_done`. The next request completes normally.

Source files
------------

// File: rtl/iso14443a_mode_sequencer_if.sv
// -----------------------------------------------------------------------------
// iso14443a_mode_sequencer_if
//
// Purpose: groups the command/status and datapath-facing signals of the
// ISO14443-A mode sequencer so they travel as one bundle between the ARM
// command path, the sequencer and the hi_iso14443a datapath.
//
// Signals (direction as seen from the sequencer, i.e. the slave modport):
//   role       in   0 = tag simulation, 1 = reader
//   sniff      in   request SNIFFER mode while idle
//   ssp_frame  in   frame strobe from the datapath
//   tx_req     in   single-cycle transmit request
//   tx_frames  in   number of frames to modulate, sampled with tx_req
//   abort      in   level, ends an active transmit early
//   mod_type   out  registered mode code to the datapath
//   tx_busy    out  transmit in progress
//   tx_done    out  one-cycle completion pulse
//   tx_status  out  completion status, valid with tx_done
//
// Modports: master drives the requests and frame strobe, slave is the
// sequencer itself.
// -----------------------------------------------------------------------------
interface iso14443a_mode_sequencer_if;
   logic       role;
   logic       sniff;
   logic       ssp_frame;
   logic       tx_req;
   logic [7:0] tx_frames;
   logic       abort;
   logic [2:0] mod_type;
   logic       tx_busy;
   logic       tx_done;
   logic [1:0] tx_status;

   modport master (
      output role, sniff, ssp_frame, tx_req, tx_frames, abort,
      input  mod_type, tx_busy, tx_done, tx_status
   );

   modport slave (
      input  role, sniff, ssp_frame, tx_req, tx_frames, abort,
      output mod_type, tx_busy, tx_done, tx_status
   );
endinterface

// File: rtl/iso14443a_mode_sequencer.sv
// -----------------------------------------------------------------------------
// iso14443a_mode_sequencer
//
// Purpose: drives the mod_type code of the hi_iso14443a front end. While idle
// it selects sniffer or listen mode; a transmit request becomes a window of
// exactly tx_frames SSP frames of modulation, framed by GUARD_CYCLES of listen
// before and after, and ends with a tx_done pulse carrying a status code
// (00 ok, 01 aborted, 10 timeout, 11 rejected).
//
// Ports:
//   ck_1356meg  in  13.56 MHz clock, all logic on its rising edge
//   reset       in  asynchronous active-high reset
//   bus         slave modport of iso14443a_mode_sequencer_if
//
// Parameters:
//   GUARD_CYCLES   listen cycles before/after the modulation window (1..255)
//   FRAME_TIMEOUT  max cycles between ssp_frame rising edges in MOD (2..65535)
//
// Optional feature: define MODSEQ_TIMEOUT_EN to build the frame watchdog that
// abandons MOD with status 10 when no ssp_frame edge arrives in time.
// -----------------------------------------------------------------------------
module iso14443a_mode_sequencer #(
   parameter int GUARD_CYCLES  = 16,
   parameter int FRAME_TIMEOUT = 1024
) (
   input  logic                              ck_1356meg,
   input  logic                              reset,
   iso14443a_mode_sequencer_if.slave         bus
);

   if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255) begin : g_guard_range
      $error("GUARD_CYCLES must be in 1..255");
   end
   if (FRAME_TIMEOUT < 2 || FRAME_TIMEOUT > 65535) begin : g_timeout_range
      $error("FRAME_TIMEOUT must be in 2..65535");
   end

   localparam logic [2:0] MT_SNIFFER = 3'b000;
   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ABORT   = 2'b01;
   localparam logic [1:0] ST_REJECT  = 2'b11;
   localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_GUARD_IN, S_MOD, S_GUARD_OUT, S_DONE
   } state_t;

   function automatic logic [2:0] listen_code(input logic r);
      return r ? 3'b011 : 3'b001;
   endfunction

   function automatic logic [2:0] mod_code(input logic r);
      return r ? 3'b100 : 3'b010;
   endfunction

   state_t     state_q, state_d;
   logic [7:0] guard_q, guard_d;
   logic [7:0] frames_q, frames_d;
   logic       role_q, role_d;
   logic       ssp_q, ssp_d;
   logic [1:0] result_q, result_d;
   logic [2:0] mod_type_q, mod_type_d;
   logic       tx_busy_q, tx_busy_d;
   logic       tx_done_q, tx_done_d;
   logic [1:0] tx_status_q, tx_status_d;
   logic       frame_edge;
`ifdef MODSEQ_TIMEOUT_EN
   localparam logic [1:0]  ST_TIMEOUT = 2'b10;
   localparam logic [15:0] WD_LAST    = 16'(FRAME_TIMEOUT - 1);
   logic [15:0] wd_q, wd_d;
`endif

   assign frame_edge = bus.ssp_frame & ~ssp_q;

   always_comb begin
      state_d     = state_q;
      guard_d     = guard_q;
      frames_d    = frames_q;
      role_d      = role_q;
      result_d    = result_q;
      ssp_d       = bus.ssp_frame;
`ifdef MODSEQ_TIMEOUT_EN
      wd_d        = wd_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.tx_req) begin
               if (!bus.sniff && bus.tx_frames != 8'd0) begin
                  state_d  = S_GUARD_IN;
                  guard_d  = GUARD_LOAD;
                  frames_d = bus.tx_frames;
                  role_d   = bus.role;
               end else begin
                  state_d  = S_DONE;
                  result_d = ST_REJECT;
               end
            end
         end
         S_GUARD_IN: begin
            if (bus.abort) begin
               state_d  = S_GUARD_OUT;
               guard_d  = GUARD_LOAD;
               result_d = ST_ABORT;
            end else if (guard_q == 8'd1) begin
               state_d  = S_MOD;
               // Clearing the history makes a frame already high at entry
               // count as a rising edge in the first MOD cycle.
               ssp_d    = 1'b0;
`ifdef MODSEQ_TIMEOUT_EN
               wd_d     = 16'd0;
`endif
            end else begin
               guard_d  = guard_q - 8'd1;
            end
         end
         S_MOD: begin
            // Abort outranks both the final frame edge and the watchdog.
            if (bus.abort) begin
               state_d  = S_GUARD_OUT;
               guard_d  = GUARD_LOAD;
               result_d = ST_ABORT;
            end else if (frame_edge) begin
`ifdef MODSEQ_TIMEOUT_EN
               wd_d     = 16'd0;
`endif
               frames_d = frames_q - 8'd1;
               if (frames_q == 8'd1) begin
                  state_d  = S_GUARD_OUT;
                  guard_d  = GUARD_LOAD;
                  result_d = ST_OK;
               end
            end
`ifdef MODSEQ_TIMEOUT_EN
            else if (wd_q == WD_LAST) begin
               state_d  = S_GUARD_OUT;
               guard_d  = GUARD_LOAD;
               result_d = ST_TIMEOUT;
            end else begin
               wd_d     = wd_q + 16'd1;
            end
`endif
         end
         S_GUARD_OUT: begin
            if (guard_q == 8'd1) begin
               state_d = S_DONE;
            end else begin
               guard_d = guard_q - 8'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they register in step
      // with the state they describe.
      case (state_d)
         S_GUARD_IN, S_GUARD_OUT: mod_type_d = listen_code(role_d);
         S_MOD:                   mod_type_d = mod_code(role_d);
         default:                 mod_type_d = bus.sniff ? MT_SNIFFER
                                                         : listen_code(bus.role);
      endcase
      tx_busy_d   = (state_d == S_GUARD_IN) || (state_d == S_MOD) ||
                    (state_d == S_GUARD_OUT);
      tx_done_d   = (state_d == S_DONE);
      tx_status_d = (state_d == S_DONE) ? result_d : tx_status_q;
   end

   always_ff @(posedge ck_1356meg or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         guard_q     <= 8'd0;
         frames_q    <= 8'd0;
         role_q      <= 1'b0;
         ssp_q       <= 1'b0;
         result_q    <= ST_OK;
         mod_type_q  <= 3'b001;
         tx_busy_q   <= 1'b0;
         tx_done_q   <= 1'b0;
         tx_status_q <= ST_OK;
`ifdef MODSEQ_TIMEOUT_EN
         wd_q        <= 16'd0;
`endif
      end else begin
         state_q     <= state_d;
         guard_q     <= guard_d;
         frames_q    <= frames_d;
         role_q      <= role_d;
         ssp_q       <= ssp_d;
         result_q    <= result_d;
         mod_type_q  <= mod_type_d;
         tx_busy_q   <= tx_busy_d;
         tx_done_q   <= tx_done_d;
         tx_status_q <= tx_status_d;
`ifdef MODSEQ_TIMEOUT_EN
         wd_q        <= wd_d;
`endif
      end
   end

   assign bus.mod_type  = mod_type_q;
   assign bus.tx_busy   = tx_busy_q;
   assign bus.tx_done   = tx_done_q;
   assign bus.tx_status = tx_status_q;

endmodule

// File: tb/tb_iso14443a_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_iso14443a_mode_sequencer
//
// Directed bench for iso14443a_mode_sequencer with GUARD_CYCLES=16 and
// FRAME_TIMEOUT=64. Inputs change and outputs are sampled 1 time unit after
// the rising clock edge. The watchdog scenario is built only when
// MODSEQ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_iso14443a_mode_sequencer;
   localparam int G  = 16;
   localparam int FT = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vecs = 0;
   int   errs = 0;

   iso14443a_mode_sequencer_if bus();

   iso14443a_mode_sequencer #(
      .GUARD_CYCLES (G),
      .FRAME_TIMEOUT(FT)
   ) dut (
      .ck_1356meg(clk),
      .reset     (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic request(input logic [7:0] n);
      bus.tx_frames = n;
      bus.tx_req    = 1'b1;
      tick();
      bus.tx_req    = 1'b0;
   endtask

   task automatic pulse();
      bus.ssp_frame = 1'b1;
      tick();
      bus.ssp_frame = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ticks(3);
      vecs++; if (bus.mod_type !== 3'b001) begin errs++; $display("FAIL reset_mod: got %b want 001", bus.mod_type); end
      vecs++; if (bus.tx_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.tx_busy); end
      vecs++; if (bus.tx_done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", bus.tx_done); end
      vecs++; if (bus.tx_status !== 2'b00) begin errs++; $display("FAIL reset_status: got %b want 00", bus.tx_status); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_idle_mode();
      bus.role = 1'b0; bus.sniff = 1'b0;
      tick();
      vecs++; if (bus.mod_type !== 3'b001) begin errs++; $display("FAIL idle_tag: got %b want 001", bus.mod_type); end
      bus.sniff = 1'b1;
      #1;
      vecs++; if (bus.mod_type !== 3'b001) begin errs++; $display("FAIL idle_latency: got %b want 001", bus.mod_type); end
      tick();
      vecs++; if (bus.mod_type !== 3'b000) begin errs++; $display("FAIL idle_sniff: got %b want 000", bus.mod_type); end
      bus.role = 1'b1; bus.sniff = 1'b0;
      tick();
      vecs++; if (bus.mod_type !== 3'b011) begin errs++; $display("FAIL idle_reader: got %b want 011", bus.mod_type); end
      bus.role = 1'b0;
      tick();
   endtask

   task automatic test_normal_tx();
      request(8'd3);
      vecs++; if (bus.tx_busy !== 1'b1) begin errs++; $display("FAIL normal_busy: got %b want 1", bus.tx_busy); end
      vecs++; if (bus.mod_type !== 3'b001) begin errs++; $display("FAIL normal_guard_in: got %b want 001", bus.mod_type); end
      ticks(G - 1);
      vecs++; if (bus.mod_type !== 3'b001) begin errs++; $display("FAIL normal_guard_end: got %b want 001", bus.mod_type); end
      tick();
      vecs++; if (bus.mod_type !== 3'b010) begin errs++; $display("FAIL normal_mod_entry: got %b want 010", bus.mod_type); end
      for (int f = 0; f < 3; f++) begin
         ticks(31);
         vecs++; if (bus.mod_type !== 3'b010) begin errs++; $display("FAIL normal_mod_hold%0d: got %b want 010", f, bus.mod_type); end
         pulse();
      end
      vecs++; if (bus.mod_type !== 3'b001) begin errs++; $display("FAIL normal_guard_out: got %b want 001", bus.mod_type); end
      ticks(G - 1);
      vecs++; if (bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b1) begin errs++; $display("FAIL normal_early_done: got done=%b busy=%b want 0/1", bus.tx_done, bus.tx_busy); end
      tick();
      vecs++; if (bus.tx_done !== 1'b1) begin errs++; $display("FAIL normal_done: got %b want 1", bus.tx_done); end
      vecs++; if (bus.tx_status !== 2'b00) begin errs++; $display("FAIL normal_status: got %b want 00", bus.tx_status); end
      vecs++; if (bus.tx_busy !== 1'b0) begin errs++; $display("FAIL normal_busy_drop: got %b want 0", bus.tx_busy); end
      tick();
      vecs++; if (bus.tx_done !== 1'b0 || bus.mod_type !== 3'b001) begin errs++; $display("FAIL normal_after: got done=%b mod=%b want 0/001", bus.tx_done, bus.mod_type); end
   endtask

   task automatic test_reject();
      request(8'd0);
      vecs++; if (bus.tx_done !== 1'b1 || bus.tx_status !== 2'b11) begin errs++; $display("FAIL reject_zero: got done=%b status=%b want 1/11", bus.tx_done, bus.tx_status); end
      vecs++; if (bus.tx_busy !== 1'b0 || bus.mod_type !== 3'b001) begin errs++; $display("FAIL reject_zero_mode: got busy=%b mod=%b want 0/001", bus.tx_busy, bus.mod_type); end
      tick();
      vecs++; if (bus.tx_done !== 1'b0 || bus.tx_status !== 2'b11) begin errs++; $display("FAIL reject_hold: got done=%b status=%b want 0/11", bus.tx_done, bus.tx_status); end
      bus.sniff = 1'b1;
      tick();
      request(8'd4);
      vecs++; if (bus.tx_done !== 1'b1 || bus.tx_status !== 2'b11) begin errs++; $display("FAIL reject_sniff: got done=%b status=%b want 1/11", bus.tx_done, bus.tx_status); end
      vecs++; if (bus.tx_busy !== 1'b0 || bus.mod_type !== 3'b000) begin errs++; $display("FAIL reject_sniff_mode: got busy=%b mod=%b want 0/000", bus.tx_busy, bus.mod_type); end
      tick();
      vecs++; if (bus.tx_busy !== 1'b0 || bus.mod_type !== 3'b000) begin errs++; $display("FAIL reject_sniff_after: got busy=%b mod=%b want 0/000", bus.tx_busy, bus.mod_type); end
      bus.sniff = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      bus.role = 1'b1;
      tick();
      request(8'd5);
      vecs++; if (bus.mod_type !== 3'b011) begin errs++; $display("FAIL abort_guard_in: got %b want 011", bus.mod_type); end
      ticks(G);
      vecs++; if (bus.mod_type !== 3'b100) begin errs++; $display("FAIL abort_mod_entry: got %b want 100", bus.mod_type); end
      bus.role = 1'b0;
      ticks(3); pulse(); ticks(3); pulse(); ticks(2);
      vecs++; if (bus.mod_type !== 3'b100) begin errs++; $display("FAIL abort_role_change: got %b want 100", bus.mod_type); end
      bus.tx_frames = 8'd1; bus.tx_req = 1'b1;
      tick();
      bus.tx_req = 1'b0;
      vecs++; if (bus.mod_type !== 3'b100 || bus.tx_done !== 1'b0) begin errs++; $display("FAIL drop_req: got mod=%b done=%b want 100/0", bus.mod_type, bus.tx_done); end
      bus.abort = 1'b1;
      tick();
      vecs++; if (bus.mod_type !== 3'b011 || bus.tx_busy !== 1'b1) begin errs++; $display("FAIL abort_listen: got mod=%b busy=%b want 011/1", bus.mod_type, bus.tx_busy); end
      ticks(2);
      bus.abort = 1'b0;
      ticks(G - 3);
      vecs++; if (bus.tx_done !== 1'b0) begin errs++; $display("FAIL abort_early_done: got %b want 0", bus.tx_done); end
      tick();
      vecs++; if (bus.tx_done !== 1'b1 || bus.tx_status !== 2'b01) begin errs++; $display("FAIL abort_status: got done=%b status=%b want 1/01", bus.tx_done, bus.tx_status); end
      tick();
      vecs++; if (bus.mod_type !== 3'b001) begin errs++; $display("FAIL abort_idle_role: got %b want 001", bus.mod_type); end
   endtask

   task automatic test_abort_final_edge();
      bus.role = 1'b1;
      tick();
      request(8'd2);
      ticks(G);
      vecs++; if (bus.mod_type !== 3'b100) begin errs++; $display("FAIL abfin_mod: got %b want 100", bus.mod_type); end
      ticks(2); pulse(); ticks(2);
      bus.ssp_frame = 1'b1; bus.abort = 1'b1;
      tick();
      bus.ssp_frame = 1'b0; bus.abort = 1'b0;
      vecs++; if (bus.mod_type !== 3'b011) begin errs++; $display("FAIL abfin_listen: got %b want 011", bus.mod_type); end
      ticks(G);
      vecs++; if (bus.tx_done !== 1'b1 || bus.tx_status !== 2'b01) begin errs++; $display("FAIL abfin_status: got done=%b status=%b want 1/01", bus.tx_done, bus.tx_status); end
      bus.role = 1'b0;
      ticks(2);
   endtask

   task automatic test_reset_mid();
      bit seen_done;
      request(8'd3);
      ticks(G);
      vecs++; if (bus.mod_type !== 3'b010) begin errs++; $display("FAIL rstmid_mod: got %b want 010", bus.mod_type); end
      ticks(3); pulse(); ticks(2);
      #2 rst = 1'b1;
      #1;
      vecs++; if (bus.mod_type !== 3'b001 || bus.tx_busy !== 1'b0) begin errs++; $display("FAIL rstmid_async: got mod=%b busy=%b want 001/0", bus.mod_type, bus.tx_busy); end
      ticks(2);
      vecs++; if (bus.tx_status !== 2'b00) begin errs++; $display("FAIL rstmid_status: got %b want 00", bus.tx_status); end
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < G + 8; i++) begin
         tick();
         if (bus.tx_done === 1'b1 || bus.tx_busy === 1'b1) seen_done = 1'b1;
      end
      vecs++; if (seen_done !== 1'b0) begin errs++; $display("FAIL rstmid_no_done: got activity=%b want 0", seen_done); end
   endtask

   task automatic test_back_to_back();
      request(8'd1);
      ticks(G);
      vecs++; if (bus.mod_type !== 3'b010) begin errs++; $display("FAIL b2b_mod1: got %b want 010", bus.mod_type); end
      ticks(2); pulse();
      vecs++; if (bus.mod_type !== 3'b001) begin errs++; $display("FAIL b2b_listen1: got %b want 001", bus.mod_type); end
      ticks(G);
      vecs++; if (bus.tx_done !== 1'b1 || bus.tx_status !== 2'b00) begin errs++; $display("FAIL b2b_done1: got done=%b status=%b want 1/00", bus.tx_done, bus.tx_status); end
      request(8'd2);
      vecs++; if (bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin errs++; $display("FAIL b2b_drop_in_done: got busy=%b done=%b want 0/0", bus.tx_busy, bus.tx_done); end
      request(8'd2);
      vecs++; if (bus.tx_busy !== 1'b1) begin errs++; $display("FAIL b2b_accept2: got %b want 1", bus.tx_busy); end
      bus.ssp_frame = 1'b1;
      ticks(G);
      vecs++; if (bus.mod_type !== 3'b010) begin errs++; $display("FAIL b2b_mod2: got %b want 010", bus.mod_type); end
      tick();
      bus.ssp_frame = 1'b0;
      ticks(3); pulse();
      vecs++; if (bus.mod_type !== 3'b001) begin errs++; $display("FAIL b2b_high_at_entry: got %b want 001", bus.mod_type); end
      ticks(G);
      vecs++; if (bus.tx_done !== 1'b1 || bus.tx_status !== 2'b00) begin errs++; $display("FAIL b2b_done2: got done=%b status=%b want 1/00", bus.tx_done, bus.tx_status); end
      tick();
   endtask

`ifdef MODSEQ_TIMEOUT_EN
   task automatic test_timeout();
      request(8'd2);
      ticks(G);
      vecs++; if (bus.mod_type !== 3'b010) begin errs++; $display("FAIL timeout_mod: got %b want 010", bus.mod_type); end
      ticks(FT - 1);
      vecs++; if (bus.mod_type !== 3'b010) begin errs++; $display("FAIL timeout_early: got %b want 010", bus.mod_type); end
      tick();
      vecs++; if (bus.mod_type !== 3'b001) begin errs++; $display("FAIL timeout_listen: got %b want 001", bus.mod_type); end
      ticks(G);
      vecs++; if (bus.tx_done !== 1'b1 || bus.tx_status !== 2'b10) begin errs++; $display("FAIL timeout_status: got done=%b status=%b want 1/10", bus.tx_done, bus.tx_status); end
      tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bus.role      = 1'b0;
      bus.sniff     = 1'b0;
      bus.ssp_frame = 1'b0;
      bus.tx_req    = 1'b0;
      bus.tx_frames = 8'd0;
      bus.abort     = 1'b0;
      test_reset();
      test_idle_mode();
      test_normal_tx();
      test_reject();
      test_abort();
      test_abort_final_edge();
      test_reset_mid();
      test_back_to_back();
`ifdef MODSEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
